demux_dispatch: RTL and testbench

DEMUX_DISPATCH -- requirements
Module: demux_dispatch

---
 rtl/demux_dispatch.sv | 142 ++++++++++++++
 tb/tb_demux_dispatch.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_dispatch.sv
// FIFO dispatcher that feeds a 1-to-4 demux: one registered Enable pulse per delivered nibble.
// Optional head-drop on stall timeout is enabled by defining DEMUX_DISPATCH_DROP_EN.
module demux_dispatch #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned STALL_LIMIT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] In_Data,
  input  logic [1:0] In_Dest,
  input  logic       In_Valid,
  output logic       In_Ready,
  input  logic [3:0] Dest_Ready,
  output logic [3:0] Out_Data,
  output logic [1:0] Sel_DeMux,
  output logic       Enable,
  output logic       Drop,
  output logic [3:0] Count
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned STALL_W = 8;
  localparam logic [STALL_W-1:0] STALL_MAX = '1;
  localparam logic [STALL_W-1:0] STALL_HIT = STALL_W'(STALL_LIMIT - 1);
  localparam logic [CNT_W-1:0]   DEPTH_C   = CNT_W'(DEPTH);
`ifdef DEMUX_DISPATCH_DROP_EN
  localparam bit DROP_ON = 1'b1;
`else
  localparam bit DROP_ON = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_BLOCKED = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic [3:0]         r_mem_data [DEPTH];
  logic [1:0]         r_mem_dest [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]   r_count, w_count_nxt;
  logic [STALL_W-1:0] r_stall, w_stall_nxt;
  logic               r_in_ready, r_enable, r_drop;
  logic [3:0]         r_out_data, w_out_data_nxt;
  logic [1:0]         r_sel, w_sel_nxt;
  logic               w_active, w_head_rdy, w_push, w_deliver, w_drop, w_pop;

  // Next-state, occupancy, stall and output decode
  always_comb begin
    w_state_nxt    = r_state;
    w_count_nxt    = r_count;
    w_stall_nxt    = r_stall;
    w_out_data_nxt = '0;
    w_sel_nxt      = '0;

    w_active   = (r_state != S_IDLE);
    w_head_rdy = Dest_Ready[r_mem_dest[r_rd_ptr]];
    w_push     = In_Valid && r_in_ready;
    w_deliver  = w_active && w_head_rdy;
    w_drop     = DROP_ON && (r_state == S_BLOCKED) && !w_head_rdy && (r_stall >= STALL_HIT);
    w_pop      = w_deliver || w_drop;

    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase

    if (w_pop)
      w_stall_nxt = '0;
    else if ((r_state == S_BLOCKED) && (r_stall != STALL_MAX))
      w_stall_nxt = r_stall + STALL_W'(1);

    if (w_deliver) begin
      w_out_data_nxt = r_mem_data[r_rd_ptr];
      w_sel_nxt      = r_mem_dest[r_rd_ptr];
    end

    // A new head (after any pop or first push) always starts in ISSUE
    case (r_state)
      S_IDLE:    if (w_push) w_state_nxt = S_ISSUE;
      S_ISSUE,
      S_BLOCKED: begin
        if (w_count_nxt == '0)
          w_state_nxt = S_IDLE;
        else if (w_pop)
          w_state_nxt = S_ISSUE;
        else
          w_state_nxt = S_BLOCKED;
      end
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_stall    <= '0;
      r_in_ready <= 1'b1;
      r_enable   <= 1'b0;
      r_drop     <= 1'b0;
      r_out_data <= '0;
      r_sel      <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count    <= w_count_nxt;
      r_stall    <= w_stall_nxt;
      r_in_ready <= (w_count_nxt < DEPTH_C);
      r_enable   <= w_deliver;
      r_drop     <= w_drop;
      r_out_data <= w_out_data_nxt;
      r_sel      <= w_sel_nxt;
    end
  end

  // Queue storage needs no reset; occupancy and pointers define validity
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= In_Data;
      r_mem_dest[r_wr_ptr] <= In_Dest;
    end
  end

  assign In_Ready  = r_in_ready;
  assign Out_Data  = r_out_data;
  assign Sel_DeMux = r_sel;
  assign Enable    = r_enable;
  assign Drop      = r_drop;
  assign Count     = r_count;

endmodule

// File: tb/tb_demux_dispatch.sv
// Self-checking bench for demux_dispatch: queue-based reference model plus directed literal checks.
module tb_demux_dispatch;

  localparam int unsigned DEPTH       = 4;
  localparam int unsigned STALL_LIMIT = 15;
`ifdef DEMUX_DISPATCH_DROP_EN
  localparam bit TB_DROP = 1'b1;
`else
  localparam bit TB_DROP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] In_Data;
  logic [1:0] In_Dest;
  logic       In_Valid;
  logic       In_Ready;
  logic [3:0] Dest_Ready;
  logic [3:0] Out_Data;
  logic [1:0] Sel_DeMux;
  logic       Enable;
  logic       Drop;
  logic [3:0] Count;

  demux_dispatch #(.DEPTH(DEPTH), .STALL_LIMIT(STALL_LIMIT)) dut (
    .clk(clk), .reset(reset),
    .In_Data(In_Data), .In_Dest(In_Dest), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .Dest_Ready(Dest_Ready),
    .Out_Data(Out_Data), .Sel_DeMux(Sel_DeMux), .Enable(Enable), .Drop(Drop), .Count(Count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  function automatic void check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: entries wait in a queue; a head leaves when its destination is ready,
  // or (drop build) after it has sat through STALL_LIMIT blocked cycles.
  typedef struct packed {
    logic [1:0] dest;
    logic [3:0] data;
  } ent_t;

  ent_t q[$];
  int   blocked_cycles;
  bit   model_on = 1'b0;
  bit   rdy_before;
  int   exp_en, exp_sel, exp_data, exp_drop;

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      blocked_cycles = 0;
      exp_en = 0; exp_sel = 0; exp_data = 0; exp_drop = 0;
      model_on = 1'b1;
    end else begin
      rdy_before = (q.size() < DEPTH);
      exp_en = 0; exp_sel = 0; exp_data = 0; exp_drop = 0;
      if (q.size() > 0) begin
        if (Dest_Ready[q[0].dest]) begin
          exp_en   = 1;
          exp_sel  = int'(q[0].dest);
          exp_data = int'(q[0].data);
          void'(q.pop_front());
          blocked_cycles = 0;
        end else if (TB_DROP && blocked_cycles == STALL_LIMIT) begin
          exp_drop = 1;
          void'(q.pop_front());
          blocked_cycles = 0;
        end else if (blocked_cycles < 1000) begin
          blocked_cycles++;
        end
      end
      if (In_Valid && rdy_before) q.push_back({In_Dest, In_Data});
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("m_enable",   int'(Enable),    exp_en);
      check("m_sel",      int'(Sel_DeMux), exp_sel);
      check("m_data",     int'(Out_Data),  exp_data);
      check("m_drop",     int'(Drop),      exp_drop);
      check("m_count",    int'(Count),     q.size());
      check("m_in_ready", int'(In_Ready),  (q.size() < DEPTH) ? 1 : 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; In_Valid = 1'b0;
    step();
    reset = 1'b0;
  endtask

  logic [1:0] rec_sel [$];
  int         rec_cyc [$];
  logic [1:0] exp_order [4];
  int         n_drop, n_en, first_after_rise, hold;

  initial begin
    reset = 1'b1; In_Valid = 1'b0; In_Data = '0; In_Dest = '0; Dest_Ready = '0;
    repeat (2) step();
    check("rst_enable", int'(Enable), 0);
    check("rst_count",  int'(Count),  0);
    check("rst_drop",   int'(Drop),   0);
    check("rst_sel",    int'(Sel_DeMux), 0);
    reset = 1'b0;
    step();
    check("post_rst_in_ready", int'(In_Ready), 1);

    // Single push, destination school, delivered two edges later
    Dest_Ready = 4'hF; In_Valid = 1'b1; In_Data = 4'hA; In_Dest = 2'b10;
    step();
    In_Valid = 1'b0;
    check("lat_count1", int'(Count),  1);
    check("lat_en0",    int'(Enable), 0);
    step();
    check("lat_en1",   int'(Enable),    1);
    check("lat_sel",   int'(Sel_DeMux), 2);
    check("lat_data",  int'(Out_Data),  10);
    check("lat_count0", int'(Count),    0);
    step();
    check("lat_en_off",  int'(Enable),    0);
    check("lat_sel_off", int'(Sel_DeMux), 0);

    // Fill to capacity; fifth offer refused
    Dest_Ready = 4'h0;
    for (int i = 0; i < 5; i++) begin
      In_Valid = 1'b1; In_Data = 4'(i + 1); In_Dest = 2'(i);
      step();
      if (i == 3) begin
        check("full_in_ready", int'(In_Ready), 0);
        check("full_count",    int'(Count),    4);
      end
    end
    In_Valid = 1'b0;
    check("full_count_after5", int'(Count), 4);
    Dest_Ready = 4'hF;
    repeat (6) step();
    check("full_drained", int'(Count), 0);

    // Back-to-back order across destinations
    exp_order[0] = 2'b00; exp_order[1] = 2'b01; exp_order[2] = 2'b11; exp_order[3] = 2'b10;
    for (int i = 0; i < 8; i++) begin
      In_Valid = (i < 4); In_Data = 4'(i + 4); In_Dest = exp_order[i % 4];
      step();
      if (Enable) begin rec_sel.push_back(Sel_DeMux); rec_cyc.push_back(i); end
    end
    In_Valid = 1'b0;
    check("order_n", rec_sel.size(), 4);
    if (rec_sel.size() == 4) begin
      for (int i = 0; i < 4; i++) check("order_sel", int'(rec_sel[i]), int'(exp_order[i]));
      check("order_consecutive", rec_cyc[3] - rec_cyc[0], 3);
    end

    // Blocked head (fire_department) behind Dest_Ready=1101
    Dest_Ready = 4'b1101;
    In_Valid = 1'b1; In_Data = 4'h5; In_Dest = 2'b01; step();
    In_Data = 4'h9; In_Dest = 2'b00; step();
    In_Valid = 1'b0;
    n_drop = 0; n_en = 0; first_after_rise = -1;
    for (int i = 0; i < 20; i++) begin
      step();
      n_drop += int'(Drop); n_en += int'(Enable);
    end
    Dest_Ready = 4'hF;
    for (int i = 1; i <= 4; i++) begin
      step();
      n_drop += int'(Drop); n_en += int'(Enable);
      if (Enable && first_after_rise < 0) first_after_rise = i;
    end
    check("stall_drops",      n_drop, TB_DROP ? 1 : 0);
    check("stall_deliveries", n_en,   TB_DROP ? 1 : 2);
    check("stall_first_rise", first_after_rise, TB_DROP ? -1 : 1);

    // Reset while delivering with three entries left
    Dest_Ready = 4'h0;
    for (int i = 0; i < 4; i++) begin
      In_Valid = 1'b1; In_Data = 4'(i + 8); In_Dest = 2'(i); step();
    end
    In_Valid = 1'b0; Dest_Ready = 4'hF;
    step();
    check("mid_en",    int'(Enable), 1);
    check("mid_count", int'(Count),  3);
    do_reset();
    check("mid_rst_en",       int'(Enable),   0);
    check("mid_rst_count",    int'(Count),    0);
    check("mid_rst_in_ready", int'(In_Ready), 1);
    n_en = 0;
    repeat (5) begin step(); n_en += int'(Enable); end
    check("mid_rst_no_deliv", n_en, 0);

    // Simultaneous push and pop at occupancy two
    Dest_Ready = 4'h0;
    In_Valid = 1'b1; In_Dest = 2'b00; In_Data = 4'h1; step();
    In_Data = 4'h2; step();
    In_Valid = 1'b0;
    check("pp_count_pre", int'(Count), 2);
    Dest_Ready = 4'hF; In_Valid = 1'b1; In_Data = 4'h3; step();
    In_Valid = 1'b0;
    check("pp_count", int'(Count),    2);
    check("pp_data1", int'(Out_Data), 1);
    step(); check("pp_data2", int'(Out_Data), 2);
    step(); check("pp_data3", int'(Out_Data), 3);

    // Randomized traffic with held ready masks and occasional reset
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        Dest_Ready = 4'($urandom_range(0, 15));
        hold = $urandom_range(1, 25);
      end
      hold--;
      In_Valid = ($urandom_range(0, 3) != 0);
      In_Data  = 4'($urandom_range(0, 15));
      In_Dest  = 2'($urandom_range(0, 3));
      reset    = ($urandom_range(0, 499) == 0);
      step();
    end
    reset = 1'b0; In_Valid = 1'b0; Dest_Ready = 4'hF;
    repeat (40) step();
    check("final_count", int'(Count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
